sorted_collector: RTL and testbench

//  Receive end of the sorter serial link. Samples the sorter's serial bit (out)

---
 rtl/sorted_collector.sv | 114 +++++++++++
 tb/tb_sorted_collector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sorted_collector.sv
// Receive end of the sorter serial link: rebuilds WIDTH-bit words,
// counts ones, flags sorted words, holds results behind ready/valid.
module sorted_collector #(
  parameter int WIDTH = 8
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       si,
  input  logic                       vi,
  input  logic                       sync,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  output logic                       srt,
  output logic                       dv,
  input  logic                       rdy,
  output logic                       ovf
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sh;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     one_acc;
  logic              brk;
  logic              seen0;

  logic              fresh;
  logic [CW-1:0]     cnt_b;
  logic [CW-1:0]     acc_b;
  logic              brk_b;
  logic              seen0_b;
  logic [WIDTH-1:0]  sh_n;
  logic [CW-1:0]     cnt_n;
  logic [CW-1:0]     acc_n;
  logic              brk_n;
  logic              seen0_n;
  logic              done;

  // Next-word accumulators; sync or IDLE start from an empty word.
  always_comb begin
    fresh   = sync || (state == IDLE);
    cnt_b   = fresh ? '0 : bit_cnt;
    acc_b   = fresh ? '0 : one_acc;
    brk_b   = fresh ? 1'b0 : brk;
    seen0_b = fresh ? 1'b0 : seen0;
    sh_n    = {sh[WIDTH-2:0], si};
    cnt_n   = cnt_b + 1'b1;
    acc_n   = acc_b + {{(CW-1){1'b0}}, si};
    brk_n   = brk_b | (si & seen0_b);
    seen0_n = seen0_b | ~si;
    done    = vi && (cnt_n == LAST);
  end

  // Framing FSM, accumulators and the ready/valid output register.
  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      one_acc <= '0;
      brk     <= 1'b0;
      seen0   <= 1'b0;
      dout    <= '0;
      ones    <= '0;
      srt     <= 1'b0;
      dv      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (vi) begin
        sh <= sh_n;
        if (done) begin
          state   <= IDLE;
          bit_cnt <= '0;
          one_acc <= '0;
          brk     <= 1'b0;
          seen0   <= 1'b0;
        end else begin
          state   <= RECV;
          bit_cnt <= cnt_n;
          one_acc <= acc_n;
          brk     <= brk_n;
          seen0   <= seen0_n;
        end
      end else if (sync) begin
        state   <= IDLE;
        bit_cnt <= '0;
        one_acc <= '0;
        brk     <= 1'b0;
        seen0   <= 1'b0;
      end

      if (done) begin
        if (!dv || rdy) begin
          dout <= sh_n;
          ones <= acc_n;
          srt  <= ~brk_n;
          dv   <= 1'b1;
        end else begin
          ovf  <= 1'b1;
        end
      end else if (dv && rdy) begin
        dv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sorted_collector.sv
// Directed bench for sorted_collector: framing, gaps,
// back-pressure drop, reset abort and sync restart.
module tb_sorted_collector;

  logic       ck = 1'b0;
  logic       reset;
  logic       si;
  logic       vi;
  logic       sync;
  logic       rdy;
  logic [7:0] dout;
  logic [3:0] ones;
  logic       srt;
  logic       dv;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  sorted_collector #(.WIDTH(8)) dut (
    .ck    (ck),
    .reset (reset),
    .si    (si),
    .vi    (vi),
    .sync  (sync),
    .dout  (dout),
    .ones  (ones),
    .srt   (srt),
    .dv    (dv),
    .rdy   (rdy),
    .ovf   (ovf)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    si = b;
    vi = 1'b1;
    tick();
    vi = 1'b0;
  endtask

  // Sends the first n bits of w, MSB first, back to back.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++)
      send_bit(w[7-i]);
  endtask

  task automatic idle(input int n);
    vi = 1'b0;
    for (int i = 0; i < n; i++)
      tick();
  endtask

  initial begin
    reset = 1'b1;
    si    = 1'b0;
    vi    = 1'b0;
    sync  = 1'b0;
    rdy   = 1'b0;
    tick();
    tick();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_srt",  32'(srt),  32'd0);
    check("rst_dv",   32'(dv),   32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    reset = 1'b0;
    rdy   = 1'b1;

    // T1
    send_bits(8'hF0, 7);
    check("t1_dv_early", 32'(dv), 32'd0);
    send_bits(8'h0F, 1);
    check("t1_dv",   32'(dv),   32'd1);
    check("t1_dout", 32'(dout), 32'hF0);
    check("t1_ones", 32'(ones), 32'd4);
    check("t1_srt",  32'(srt),  32'd1);
    idle(1);
    check("t1_dv_drop", 32'(dv), 32'd0);

    // T2
    send_bits(8'h55, 8);
    check("t2_dv",   32'(dv),   32'd1);
    check("t2_dout", 32'(dout), 32'h55);
    check("t2_ones", 32'(ones), 32'd4);
    check("t2_srt",  32'(srt),  32'd0);
    idle(1);
    check("t2_dv_pulse", 32'(dv), 32'd0);

    // T3
    for (int i = 0; i < 7; i++) begin
      send_bit(i < 4);
      idle(3);
    end
    check("t3_dv_early", 32'(dv), 32'd0);
    send_bit(1'b0);
    check("t3_dv",   32'(dv),   32'd1);
    check("t3_dout", 32'(dout), 32'hF0);
    check("t3_ones", 32'(ones), 32'd4);
    check("t3_srt",  32'(srt),  32'd1);
    idle(1);
    check("t3_dv_drop", 32'(dv), 32'd0);

    // T4
    rdy = 1'b0;
    send_bits(8'hC0, 8);
    check("t4_dv1",  32'(dv),   32'd1);
    check("t4_dout1", 32'(dout), 32'hC0);
    check("t4_ovf1", 32'(ovf),  32'd0);
    idle(2);
    check("t4_dv_hold", 32'(dv), 32'd1);
    send_bits(8'h3F, 8);
    check("t4_dout", 32'(dout), 32'hC0);
    check("t4_ones", 32'(ones), 32'd2);
    check("t4_srt",  32'(srt),  32'd1);
    check("t4_ovf",  32'(ovf),  32'd1);
    check("t4_dv",   32'(dv),   32'd1);
    rdy = 1'b1;
    idle(1);
    check("t4_dv_acc", 32'(dv),  32'd0);
    check("t4_ovf_st", 32'(ovf), 32'd1);

    // T5
    send_bits(8'h00, 5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t5_ovf_rst", 32'(ovf), 32'd0);
    check("t5_dv_rst",  32'(dv),  32'd0);
    send_bits(8'hFF, 7);
    check("t5_dv_early", 32'(dv), 32'd0);
    send_bits(8'hFF, 1);
    check("t5_dv",   32'(dv),   32'd1);
    check("t5_dout", 32'(dout), 32'hFF);
    check("t5_ones", 32'(ones), 32'd8);
    check("t5_srt",  32'(srt),  32'd1);
    check("t5_ovf",  32'(ovf),  32'd0);
    idle(1);

    // T6
    send_bits(8'hFF, 3);
    sync = 1'b1;
    send_bit(1'b0);
    sync = 1'b0;
    send_bits(8'h00, 6);
    check("t6_dv_early", 32'(dv), 32'd0);
    send_bit(1'b0);
    check("t6_dv",   32'(dv),   32'd1);
    check("t6_dout", 32'(dout), 32'h00);
    check("t6_ones", 32'(ones), 32'd0);
    check("t6_srt",  32'(srt),  32'd1);

    // Accept and reload on the same edge.
    rdy = 1'b0;
    send_bits(8'h81, 7);
    check("t7_dv_hold", 32'(dv),   32'd1);
    check("t7_dout_old", 32'(dout), 32'h00);
    rdy = 1'b1;
    send_bit(1'b1);
    check("t7_dv",   32'(dv),   32'd1);
    check("t7_dout", 32'(dout), 32'h81);
    check("t7_ones", 32'(ones), 32'd2);
    check("t7_srt",  32'(srt),  32'd0);
    check("t7_ovf",  32'(ovf),  32'd0);
    idle(1);
    check("t7_dv_drop", 32'(dv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
